// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - host-side request/response bus of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ready;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port dmem arbiter: core has absolute priority, host issued in core-idle cycles
module dmem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  core_mem_en,
  input  logic                  core_store_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,

  dmem_arbiter_if.slave         host_bus,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  host_starved,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  held_we;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [DATA_WIDTH-1:0] held_wdata;
  logic [WCW-1:0]        wait_cnt;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  capture;
  logic                  blocked;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host_bus.host_req) state_nxt = PEND;
      PEND:    if (!core_mem_en)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue is masked by rst so a discarded held op never reaches the memory.
  always_comb begin
    host_bus.host_ready = (state == IDLE) && !rst;
    capture             = host_bus.host_ready && host_bus.host_req;
    blocked             = (state == PEND) && core_mem_en;
    issue               = (state == PEND) && !core_mem_en && !rst;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_mem_en) begin
      mem_en    = 1'b1;
      mem_we    = core_store_en;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (issue) begin
      mem_en    = 1'b1;
      mem_we    = held_we;
      mem_addr  = held_addr;
      mem_wdata = held_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_we      <= 1'b0;
      held_addr    <= '0;
      held_wdata   <= '0;
      wait_cnt     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      conflict_cnt <= '0;
    end else begin
      rvalid_q <= issue && !held_we;
      if (capture) begin
        held_we    <= host_bus.host_we;
        held_addr  <= host_bus.host_addr;
        held_wdata <= host_bus.host_wdata;
        wait_cnt   <= '0;
      end
      if (blocked) begin
        if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (conflict_cnt != '1)  conflict_cnt <= conflict_cnt + 1'b1;
      end
      if (issue && !held_we) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign core_rdata           = mem_rdata;
  assign host_bus.host_rvalid = rvalid_q && !rst;
  assign host_bus.host_rdata  = rdata_q;
  assign host_starved         = (state == PEND) && (wait_cnt >= WAIT_MAX);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (default and 4-bit counter instances)
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mop_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          core_mem_en;
  logic          core_store_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          host_starved;
  logic [15:0]   conflict_cnt;

  logic [DW-1:0] core_rdata4;
  logic          mem_en4;
  logic          mem_we4;
  logic [AW-1:0] mem_addr4;
  logic [DW-1:0] mem_wdata4;
  logic          host_starved4;
  logic [3:0]    conflict_cnt4;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif4 ();

  assign hif4.host_req   = hif.host_req;
  assign hif4.host_we    = hif.host_we;
  assign hif4.host_addr  = hif.host_addr;
  assign hif4.host_wdata = hif.host_wdata;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .core_mem_en(core_mem_en), .core_store_en(core_store_en),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .host_bus(hif.slave),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .host_starved(host_starved), .conflict_cnt(conflict_cnt)
  );

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .core_mem_en(core_mem_en), .core_store_en(core_store_en),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata4),
    .host_bus(hif4.slave),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata),
    .host_starved(host_starved4), .conflict_cnt(conflict_cnt4)
  );

  logic [DW-1:0] memarr [0:255];
  assign mem_rdata = memarr[mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_we) memarr[mem_addr[7:0]] = mem_wdata;

  int total = 0;
  int bad   = 0;
  mop_t          exp_mem [$];
  logic [DW-1:0] exp_rd  [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory op and every rvalid pulse must match the next queued expectation.
  always @(negedge clk) begin
    mop_t m;
    chk("core_rdata", core_rdata, memarr[mem_addr[7:0]]);
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected", {63'd0, mem_en}, 64'd0);
      end else begin
        m = exp_mem.pop_front();
        chk("mem_we", {63'd0, mem_we}, {63'd0, m.we});
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, m.addr});
        chk("mem_wdata", mem_wdata, m.wdata);
      end
    end else begin
      chk("mem_idle_bus", {31'd0, mem_we, mem_addr} | mem_wdata, 64'd0);
    end
    if (hif.host_rvalid) begin
      if (exp_rd.size() == 0) chk("rvalid_unexpected", {63'd0, hif.host_rvalid}, 64'd0);
      else chk("host_rdata", hif.host_rdata, exp_rd.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_mem_en     = 1'b0;
    core_store_en   = 1'b0;
    core_addr       = '0;
    core_wdata      = '0;
    hif.host_req    = 1'b0;
    hif.host_we     = 1'b0;
    hif.host_addr   = '0;
    hif.host_wdata  = '0;
  endtask

  task automatic core_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_mem_en   = 1'b1;
    core_store_en = we;
    core_addr     = a;
    core_wdata    = d;
    exp_mem.push_back('{we: we, addr: a, wdata: d});
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hif.host_req   = 1'b1;
    hif.host_we    = we;
    hif.host_addr  = a;
    hif.host_wdata = d;
  endtask

  task automatic expect_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_mem.push_back('{we: we, addr: a, wdata: d});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memarr[i] = '0;
    memarr[8'h10] = 64'hA5;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("ready_in_reset", {63'd0, hif.host_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {63'd0, hif.host_ready}, 64'd1);
    chk("rst_rvalid", {63'd0, hif.host_rvalid}, 64'd0);
    chk("rst_rdata", hif.host_rdata, 64'd0);
    chk("rst_starved", {63'd0, host_starved}, 64'd0);
    chk("rst_conflict", {48'd0, conflict_cnt}, 64'd0);
    cyc();

    // Host read on idle core: capture, issue next cycle, rvalid the cycle after.
    host_op(1'b0, 32'h10, 64'd0);
    #1 chk("t1_ready_capture", {63'd0, hif.host_ready}, 64'd1);
    cyc();
    idle_inputs();
    expect_issue(1'b0, 32'h10, 64'd0);
    exp_rd.push_back(64'hA5);
    cyc();
    chk("t1_conflict", {48'd0, conflict_cnt}, 64'd0);

    // Host write blocked by 5 core loads.
    host_op(1'b1, 32'h20, 64'h1234);
    cyc();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      core_op(1'b0, 32'h40 + 32'(i * 8), 64'd0);
      #1 chk("t2_ready_blocked", {63'd0, hif.host_ready}, 64'd0);
      cyc();
    end
    idle_inputs();
    expect_issue(1'b1, 32'h20, 64'h1234);
    cyc();
    chk("t2_conflict", {48'd0, conflict_cnt}, 64'd5);
    chk("t2_conflict4", {60'd0, conflict_cnt4}, 64'd5);
    chk("t2_ready_after_issue", {63'd0, hif.host_ready}, 64'd1);

    // Read back the host write, accepted in the cycle right after issue.
    host_op(1'b0, 32'h20, 64'd0);
    cyc();
    idle_inputs();
    expect_issue(1'b0, 32'h20, 64'd0);
    exp_rd.push_back(64'h1234);
    cyc();

    // Core store in the host capture cycle; host read of that address sees the store.
    core_op(1'b1, 32'h8, 64'hFF);
    host_op(1'b0, 32'h8, 64'd0);
    cyc();
    idle_inputs();
    expect_issue(1'b0, 32'h8, 64'd0);
    exp_rd.push_back(64'hFF);
    cyc();
    cyc();

    // Starvation: 20 blocked cycles, starved from blocked cycle 17 until the issue.
    host_op(1'b0, 32'h10, 64'd0);
    cyc();
    idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      core_op(1'b0, 32'h80, 64'd0);
      #1 chk($sformatf("t3_starved_k%0d", k), {63'd0, host_starved}, {63'd0, (k >= 17)});
      cyc();
    end
    idle_inputs();
    expect_issue(1'b0, 32'h10, 64'd0);
    exp_rd.push_back(64'hA5);
    #1 chk("t3_starved_issue", {63'd0, host_starved}, 64'd1);
    cyc();
    chk("t3_starved_after", {63'd0, host_starved}, 64'd0);
    chk("t3_conflict", {48'd0, conflict_cnt}, 64'd25);
    chk("t3_conflict4_sat", {60'd0, conflict_cnt4}, 64'd15);
    cyc();

    // Reset while a read is pending: the held op is discarded.
    host_op(1'b0, 32'h10, 64'd0);
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_ready", {63'd0, hif.host_ready}, 64'd1);
    chk("t5_rvalid", {63'd0, hif.host_rvalid}, 64'd0);
    chk("t5_conflict", {48'd0, conflict_cnt}, 64'd0);
    chk("t5_conflict4", {60'd0, conflict_cnt4}, 64'd0);
    chk("t5_starved", {63'd0, host_starved}, 64'd0);
    cyc();
    cyc();

    // Reset in the rvalid cycle suppresses the pulse.
    host_op(1'b0, 32'h10, 64'd0);
    cyc();
    idle_inputs();
    expect_issue(1'b0, 32'h10, 64'd0);
    cyc();
    rst = 1'b1;
    #1 chk("t6_rvalid_in_reset", {63'd0, hif.host_rvalid}, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    chk("exp_mem_left", 64'(exp_mem.size()), 64'd0);
    chk("exp_rd_left", 64'(exp_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the 4-stage pipeline core and a host/NIC-side requester. The core has no stall path, so it always has absolute priority; the host gets the memory only in cycles where the core does not access it. Host requests are captured in a one-entry holding register and issued in the first core-idle cycle. Read data is returned to the host one cycle after issue, together with starvation status and contention statistics.

Parameters:
DATA_WIDTH, 64, memory word width
ADDR_WIDTH, 32, memory address width (matches the core dmem address)
WAIT_LIMIT, 16, pending-wait cycles after which host_starved asserts
CNT_WIDTH, 16, width of the saturating conflict counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
core_mem_en  input  1  core accesses memory this cycle
core_store_en  input  1  core access is a write; ignored unless core_mem_en=1
core_addr  input  ADDR_WIDTH  core address
core_wdata  input  DATA_WIDTH  core store data
core_rdata  output  DATA_WIDTH  core load data, combinational copy of mem_rdata
host_req  input  1  host request valid
host_we  input  1  host request is a write
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  DATA_WIDTH  host write data
host_ready  output  1  arbiter can accept a host request this cycle
host_rvalid  output  1  one-cycle pulse: host_rdata is valid
host_rdata  output  DATA_WIDTH  registered host read data
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, combinational (asynchronous) read
host_starved  output  1  pending host request has waited at least WAIT_LIMIT cycles
conflict_cnt  output  CNT_WIDTH  saturating count of host-blocked cycles

Behaviour:
- Clocking and reset:
  - One clock; all state updates on the posedge of clk.
  - rst is synchronous and active-high.
  - On rst: state=IDLE; holding register cleared; wait_cnt=0; host_rvalid=0; host_rdata=0; host_starved=0; conflict_cnt=0.
- State machine, states IDLE and PEND:
  - host_ready = (state==IDLE) and rst=0.
  - IDLE: if host_req=1, capture {host_we, host_addr, host_wdata} into the holding register, clear wait_cnt, and go to PEND. The host op is never issued in its capture cycle.
  - PEND with core_mem_en=1: the core drives the memory.
    - wait_cnt increments, saturating at WAIT_LIMIT.
    - conflict_cnt increments, saturating at all-ones.
    - State stays PEND.
  - PEND with core_mem_en=0: the held op drives the memory (mem_en=1, mem_we=held_we, held addr/data). Next state is IDLE.
    - If held_we=0: host_rdata <= mem_rdata at this edge, and host_rvalid=1 for exactly the following cycle.
    - If held_we=1: no host_rvalid pulse.
- Memory mux:
  - core_mem_en=1: mem_en=1, mem_we=core_store_en, mem_addr=core_addr, mem_wdata=core_wdata. The core path is purely combinational, zero added latency.
  - Otherwise, in the PEND issue cycle: memory driven from the holding register.
  - Otherwise: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rdata = mem_rdata at all times. The core ignores it unless it is loading.
- Starvation: host_starved = (state==PEND) and (wait_cnt >= WAIT_LIMIT). It deasserts in the issue cycle's successor, i.e. once state returns to IDLE.
- Throughput: at most one host op per 2 cycles, because the capture cycle and the issue cycle are distinct. Back-to-back host requests: the second is accepted in the cycle after issue.
- Boundary conditions:
  - host_req while host_ready=0: not accepted. The host must hold its request stable until host_ready=1.
  - core_store_en=1 with core_mem_en=0: no write; treated as core idle.
  - Reset in PEND: the held op is discarded and never reaches memory; no host_rvalid.
  - Reset in the rvalid cycle: host_rvalid forced to 0.
  - conflict_cnt never wraps; it holds at 2^CNT_WIDTH-1.

Test Plan:
- Idle core, host read addr 0x10, mem holds 0xA5 -> capture at cycle 0; mem_en=1, mem_we=0, mem_addr=0x10 at cycle 1; host_rvalid=1, host_rdata=0xA5 at cycle 2; conflict_cnt=0.
- Host write addr 0x20 data 0x1234 while core_mem_en=1 for 5 cycles -> memory shows core signals for those 5 cycles; host write issued in cycle 6; conflict_cnt=5; no host_rvalid.
- Core load every cycle for 20 cycles, host read pending, WAIT_LIMIT=16 -> host_starved rises after the 16th blocked cycle and stays high until the issue; then the read completes and host_starved=0.
- Core store (core_mem_en=1, core_store_en=1, addr 0x8, data 0xFF) in the same cycle host_req is captured -> mem_we=1, mem_addr=0x8, mem_wdata=0xFF that cycle; host op issued in the next core-idle cycle.
- Host read pending, rst asserted for 1 cycle -> next cycle: state=IDLE, host_ready=1, host_rvalid=0, conflict_cnt=0; the held op never appears on the mem_* outputs.
- CNT_WIDTH=4, 20 blocked cycles -> conflict_cnt saturates at 15.
